// File: rtl/vmicro16_timer_multi_apb_pkg.sv
// -----------------------------------------------------------------------------
// vmicro16_timer_multi_apb_pkg
// Shared definitions for the multi-channel APB timer: register offsets within
// a channel's 4-word window and the bit positions inside CTRL and STATUS.
// -----------------------------------------------------------------------------
package vmicro16_timer_multi_apb_pkg;

   // Register offset inside one channel window (S_PADDR[1:0]).
   typedef enum logic [1:0] {
      REG_LOAD   = 2'd0,
      REG_COUNT  = 2'd1,
      REG_CTRL   = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   // CTRL bit indices.
   localparam int CTRL_EN       = 0;
   localparam int CTRL_ONESHOT  = 1;
   localparam int CTRL_IRQ_EN   = 2;
   localparam int CTRL_RELOAD   = 3;  // write-only strobe, always reads 0
   localparam int CTRL_PRESCALE = 8;  // PRESCALE field starts here

   // STATUS bit indices.
   localparam int STATUS_EXPIRED = 0;

endpackage : vmicro16_timer_multi_apb_pkg

// File: rtl/vmicro16_timer_chan.sv
// -----------------------------------------------------------------------------
// vmicro16_timer_chan
// One timer channel: LOAD/COUNT registers, control fields, prescaler and the
// sticky expiry flag.  The bus decode lives in the parent; this block only sees
// per-register write strobes and the write data.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   wr_load/ctrl/status  one-cycle write strobes for this channel
//   wdata             write data
//   load_o, count_o, ctrl_o, status_o   register read-back values
//   out               one-cycle pulse on expiry
//   irq               level interrupt = STATUS[0] & IRQ_EN
// -----------------------------------------------------------------------------
module vmicro16_timer_chan
   import vmicro16_timer_multi_apb_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_load,
   input  logic                  wr_ctrl,
   input  logic                  wr_status,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] load_o,
   output logic [DATA_WIDTH-1:0] count_o,
   output logic [DATA_WIDTH-1:0] ctrl_o,
   output logic [DATA_WIDTH-1:0] status_o,
   output logic                  out,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0]     load_q,     load_d;
   logic [DATA_WIDTH-1:0]     count_q,    count_d;
   logic [PRESCALE_WIDTH-1:0] presc_q,    presc_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic                      en_q,       en_d;
   logic                      oneshot_q,  oneshot_d;
   logic                      irq_en_q,   irq_en_d;
   logic                      status_q,   status_d;
   logic                      out_q,      out_d;
   logic                      tick;
   logic                      expire;

   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no
      // path through the if/else tree leaves it unassigned (no latches).
      load_d     = load_q;
      count_d    = count_q;
      presc_d    = presc_q;
      prescale_d = prescale_q;
      en_d       = en_q;
      oneshot_d  = oneshot_q;
      irq_en_d   = irq_en_q;
      status_d   = status_q;
      tick       = 1'b0;
      expire     = 1'b0;

      // A LOAD or CTRL write owns the channel for that edge: the prescaler and
      // counter do not advance, so software sees exactly what it wrote.
      if (wr_load) begin
         load_d  = wdata;
         count_d = wdata;
         presc_d = '0;
      end else if (wr_ctrl) begin
         en_d       = wdata[CTRL_EN];
         oneshot_d  = wdata[CTRL_ONESHOT];
         irq_en_d   = wdata[CTRL_IRQ_EN];
         prescale_d = wdata[CTRL_PRESCALE +: PRESCALE_WIDTH];
         if (wdata[CTRL_RELOAD] || !wdata[CTRL_EN]) begin
            presc_d = '0;
         end
         if (wdata[CTRL_RELOAD]) begin
            count_d = load_q;
         end
      end else if (en_q) begin
         if (presc_q == prescale_q) begin
            tick    = 1'b1;
            presc_d = '0;
         end else begin
            presc_d = presc_q + PRESCALE_WIDTH'(1);
         end
      end else begin
         presc_d = '0;
      end

      if (tick) begin
         if (count_q != '0) begin
            count_d = count_q - DATA_WIDTH'(1);
         end else begin
            expire = 1'b1;
            if (oneshot_q) begin
               en_d = 1'b0;        // COUNT stays at 0
            end else begin
               count_d = load_q;
            end
         end
      end

      // Clear first, then set: an expiry on the same edge as a W1C wins.
      if (wr_status && wdata[STATUS_EXPIRED]) begin
         status_d = 1'b0;
      end
      if (expire) begin
         status_d = 1'b1;
      end

      out_d = expire;
   end

   // NOTE: all state, including LOAD, is cleared by reset so a channel always
   // comes out of reset idle with a defined payload on int_data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_q     <= '0;
         count_q    <= '0;
         presc_q    <= '0;
         prescale_q <= '0;
         en_q       <= 1'b0;
         oneshot_q  <= 1'b0;
         irq_en_q   <= 1'b0;
         status_q   <= 1'b0;
         out_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // values computed above, independent of statement order.
         load_q     <= load_d;
         count_q    <= count_d;
         presc_q    <= presc_d;
         prescale_q <= prescale_d;
         en_q       <= en_d;
         oneshot_q  <= oneshot_d;
         irq_en_q   <= irq_en_d;
         status_q   <= status_d;
         out_q      <= out_d;
      end
   end

   always_comb begin
      ctrl_o                                       = '0;
      ctrl_o[CTRL_EN]                              = en_q;
      ctrl_o[CTRL_ONESHOT]                         = oneshot_q;
      ctrl_o[CTRL_IRQ_EN]                          = irq_en_q;
      ctrl_o[CTRL_PRESCALE +: PRESCALE_WIDTH]      = prescale_q;
   end

   assign load_o   = load_q;
   assign count_o  = count_q;
   assign status_o = {{(DATA_WIDTH-1){1'b0}}, status_q};
   assign out      = out_q;
   assign irq      = status_q & irq_en_q;

endmodule : vmicro16_timer_chan

// File: rtl/vmicro16_timer_multi_apb.sv
// -----------------------------------------------------------------------------
// vmicro16_timer_multi_apb
// APB slave wrapping CHANNELS independent down-counting timers.  Address is
// {channel, reg[1:0]}; zero wait states; reads are combinational.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   S_PADDR                    {channel index, register offset}
//   S_PWRITE/S_PSELx/S_PENABLE APB control
//   S_PWDATA / S_PRDATA        write / read data (read is 0 when idle)
//   S_PREADY                   S_PSELx & S_PENABLE
//   out[ch]                    one-cycle expiry pulse
//   irq[ch]                    STATUS[0] & IRQ_EN
//   int_data[ch*DW +: DW]      LOAD value of channel ch
// -----------------------------------------------------------------------------
module vmicro16_timer_multi_apb
   import vmicro16_timer_multi_apb_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int CHANNELS       = 4,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [$clog2(CHANNELS)+1:0]      S_PADDR,
   input  logic                             S_PWRITE,
   input  logic                             S_PSELx,
   input  logic                             S_PENABLE,
   input  logic [DATA_WIDTH-1:0]            S_PWDATA,
   output logic [DATA_WIDTH-1:0]            S_PRDATA,
   output logic                             S_PREADY,
   output logic [CHANNELS-1:0]              out,
   output logic [CHANNELS-1:0]              irq,
   output logic [CHANNELS*DATA_WIDTH-1:0]   int_data
);

   localparam int ADDR_W = $clog2(CHANNELS) + 2;

   logic              access;
   logic              wr;
   logic [ADDR_W-1:0] chan_sel;   // full-width so indices >= CHANNELS never alias
   reg_sel_e          reg_sel;

   logic [DATA_WIDTH-1:0] load_a   [CHANNELS];
   logic [DATA_WIDTH-1:0] count_a  [CHANNELS];
   logic [DATA_WIDTH-1:0] ctrl_a   [CHANNELS];
   logic [DATA_WIDTH-1:0] status_a [CHANNELS];

   assign access   = S_PSELx & S_PENABLE;
   assign S_PREADY = access;
   assign wr       = access & S_PWRITE;
   assign chan_sel = S_PADDR >> 2;
   assign reg_sel  = reg_sel_e'(S_PADDR[1:0]);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic hit;
      assign hit = wr && (chan_sel == ADDR_W'(g));

      vmicro16_timer_chan #(
         .DATA_WIDTH     (DATA_WIDTH),
         .PRESCALE_WIDTH (PRESCALE_WIDTH)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .wr_load   (hit && (reg_sel == REG_LOAD)),
         .wr_ctrl   (hit && (reg_sel == REG_CTRL)),
         .wr_status (hit && (reg_sel == REG_STATUS)),
         .wdata     (S_PWDATA),
         .load_o    (load_a[g]),
         .count_o   (count_a[g]),
         .ctrl_o    (ctrl_a[g]),
         .status_o  (status_a[g]),
         .out       (out[g]),
         .irq       (irq[g])
      );

      assign int_data[g*DATA_WIDTH +: DATA_WIDTH] = load_a[g];
   end

   always_comb begin
      S_PRDATA = '0;
      if (access) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (chan_sel == ADDR_W'(i)) begin
               case (reg_sel)
                  REG_LOAD:   S_PRDATA = load_a[i];
                  REG_COUNT:  S_PRDATA = count_a[i];
                  REG_CTRL:   S_PRDATA = ctrl_a[i];
                  REG_STATUS: S_PRDATA = status_a[i];
                  default:    S_PRDATA = '0;
               endcase
            end
         end
      end
   end

endmodule : vmicro16_timer_multi_apb

// File: doc/vmicro16_timer_multi_apb.md
VMICRO16_TIMER_MULTI_APB -- requirements
Module: vmicro16_timer_multi_apb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, register and bus data width.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent timer channels (1..8).
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 8, per-channel prescaler width (must be <= DATA_WIDTH-8).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port S_PADDR  input  clog2(CHANNELS)+2  address {channel, reg[1:0]}.
REQ-007 SHALL have ports S_PWRITE, S_PSELx, S_PENABLE  input  1 each  APB control.
REQ-008 SHALL have port S_PWDATA  input  DATA_WIDTH  write data.
REQ-009 SHALL have port S_PRDATA  output  DATA_WIDTH  read data.
REQ-010 SHALL have port S_PREADY  output  1  transfer complete.
REQ-011 SHALL have port out  output  CHANNELS  one-cycle expiry pulse per channel.
REQ-012 SHALL have port irq  output  CHANNELS  level interrupt = STATUS & IRQ_EN per channel.
REQ-013 SHALL have port int_data  output  CHANNELS*DATA_WIDTH  per-channel interrupt payload = that channel's LOAD value.

Function
REQ-014 SHALL assert S_PREADY = S_PSELx & S_PENABLE (zero wait states); access active when both high.
REQ-015 SHALL drive S_PRDATA = 0 when no access is active; otherwise the addressed register, combinationally.
REQ-016 SHALL decode reg 0 LOAD (R/W), 1 COUNT (R; writes ignored), 2 CTRL (R/W), 3 STATUS (R, write-1-to-clear bit 0); channel index >= CHANNELS reads 0, writes ignored.
REQ-017 SHALL define CTRL bits: b0 EN, b1 ONESHOT, b2 IRQ_EN, b3 RELOAD strobe (self-clearing, reads 0), b[8 +: PRESCALE_WIDTH] PRESCALE.
REQ-018 SHALL, on LOAD write, set LOAD and COUNT to S_PWDATA and clear the channel prescaler in the same edge.
REQ-019 SHALL, on CTRL write with RELOAD=1, set COUNT to LOAD and clear the prescaler; other fields written normally.
REQ-020 SHALL generate a tick each PRESCALE+1 clocks while EN=1; prescaler holds at 0 while EN=0.
REQ-021 SHALL, on tick with COUNT != 0, decrement COUNT by 1.
REQ-022 SHALL, on tick with COUNT == 0 (expiry): pulse out[ch] for exactly one cycle, set STATUS[0]; periodic mode reloads COUNT from LOAD; one-shot mode clears EN and holds COUNT at 0.
REQ-023 SHALL, with LOAD=0 periodic and PRESCALE=0, expire every clock.
REQ-024 SHALL give a register write priority over tick activity on the same edge for that channel (no decrement, no expiry that cycle).
REQ-025 SHALL, when STATUS W1C and expiry occur on the same edge, leave STATUS[0]=1 (set wins).
REQ-026 SHALL keep channels fully independent; accesses to one channel never perturb another.
REQ-027 SHALL wrap no counter: decrement only from nonzero values.

Reset
REQ-028 SHALL, on reset low, asynchronously clear LOAD, COUNT, CTRL, STATUS, prescalers of all channels; out=0, irq=0, S_PRDATA=0.
REQ-029 SHALL, on reset asserted mid-count, abandon the count; after release all channels idle (EN=0) until reprogrammed.

Structure
REQ-030 SHALL place register offsets (LOAD/COUNT/CTRL/STATUS) and CTRL bit indices in the shared vmicro16 config/package include.
REQ-031 SHALL implement one channel (prescaler, counter, mode, status) as sub-module vmicro16_timer_chan, instantiated CHANNELS times via generate.
REQ-032 SHALL keep APB decode and read mux in the top module only.

Verification
REQ-033 SHALL check: ch0 LOAD=3, CTRL=EN|PRESCALE=0 -> COUNT 3,2,1,0, out[0] pulse on 4th tick edge, COUNT back to 3, STATUS=1.
REQ-034 SHALL check: ch1 LOAD=2, CTRL=EN|ONESHOT|IRQ_EN|PRESCALE=3 -> ticks every 4 clocks, single out[1] pulse after 12 clocks, EN reads 0, irq[1]=1 until STATUS write 1.
REQ-035 SHALL check: STATUS W1C on the exact expiry cycle of ch0 (LOAD=0, EN) -> STATUS remains 1.
REQ-036 SHALL check: LOAD write to ch2 while counting at COUNT=5 -> COUNT equals new value next cycle, no decrement that edge, ch0/ch1 unaffected.
REQ-037 SHALL check: reset low mid-count on all channels -> all registers read 0, out=0, irq=0 immediately and after release.
REQ-038 SHALL check: read of unmapped channel (CHANNELS=3, ch3) -> S_PRDATA=0, S_PREADY=1, write ignored.
